// File: rtl/axis_rx_lane_packer_if.sv
// Bus bundle for axis_rx_lane_packer: AXI-Stream beat input, packed-word output
// and the protocol-error flag. slave = packer side, master = upstream/consumer side.
interface axis_rx_lane_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 64
);
  localparam int KB  = DATA_WIDTH / 8;
  localparam int OKB = OUT_WIDTH / 8;

  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_WIDTH-1:0] TDATA;
  logic [KB-1:0]         TKEEP;
  logic [KB-1:0]         TSTRB;
  logic                  TLAST;
  logic                  TID;
  logic [1:0]            TUSER;
  logic [7:0]            TDEST;

  logic [OUT_WIDTH-1:0]  out_data;
  logic [OKB-1:0]        out_keep;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  out_id;
  logic [1:0]            out_user;
  logic                  proto_err;

  modport slave (
    input  TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TUSER, TDEST, out_ready,
    output TREADY, out_data, out_keep, out_valid, out_last, out_id, out_user,
           proto_err
  );

  modport master (
    output TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TUSER, TDEST, out_ready,
    input  TREADY, out_data, out_keep, out_valid, out_last, out_id, out_user,
           proto_err
  );
endinterface

// File: rtl/axis_rx_lane_packer.sv
// AXI-Stream receiver packing DATA_WIDTH beats little-endian into OUT_WIDTH words.
// Optional sticky protocol monitor enabled by defining AXIS_RX_PROTOCOL_CHECK_EN.
module axis_rx_lane_packer #(
  parameter int         DATA_WIDTH = 16,
  parameter int         OUT_WIDTH  = 64,
  parameter logic [7:0] DEST_ID    = 8'h00
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axis_rx_lane_packer_if.slave s
);
  localparam int BEATS = OUT_WIDTH / DATA_WIDTH;
  localparam int KB    = DATA_WIDTH / 8;
  localparam int OKB   = OUT_WIDTH / 8;
  localparam int IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t               state;
  logic [IDXW-1:0]      idx;
  logic [OUT_WIDTH-1:0] data_q;
  logic [OKB-1:0]       keep_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 id_q;
  logic [1:0]           user_q;

  logic                 tready;
  logic                 hs;
  logic                 dest_match;
  logic                 final_beat;
  int unsigned          lane_base;
  logic [OUT_WIDTH-1:0] data_next;
  logic [OKB-1:0]       keep_next;

  assign tready     = !ARESET && (state == COLLECT);
  assign hs         = s.TVALID && tready;
  assign dest_match = (s.TDEST == DEST_ID);
  assign final_beat = (idx == IDXW'(BEATS - 1)) || s.TLAST;
  assign lane_base  = KB * idx;

  // Merge the incoming beat into the current accumulator at byte lane idx*KB.
  always_comb begin
    data_next = data_q;
    keep_next = keep_q;
    for (int unsigned b = 0; b < KB; b++) begin
      data_next[(lane_base + b) * 8 +: 8] =
        (s.TKEEP[b] && s.TSTRB[b]) ? s.TDATA[b * 8 +: 8] : 8'h00;
      keep_next[lane_base + b] = s.TKEEP[b];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= COLLECT;
      idx     <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      id_q    <= 1'b0;
      user_q  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (hs && dest_match) begin
            data_q <= data_next;
            keep_q <= keep_next;
            if (idx == '0) begin
              id_q   <= s.TID;
              user_q <= s.TUSER;
            end
            if (final_beat) begin
              state   <= HOLD;
              valid_q <= 1'b1;
              last_q  <= s.TLAST;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (valid_q && s.out_ready) begin
            state   <= COLLECT;
            idx     <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        default: begin
          state <= COLLECT;
          idx   <= '0;
        end
      endcase
    end
  end

  assign s.TREADY    = tready;
  assign s.out_data  = data_q;
  assign s.out_keep  = keep_q;
  assign s.out_valid = valid_q;
  assign s.out_last  = last_q;
  assign s.out_id    = id_q;
  assign s.out_user  = user_q;

`ifdef AXIS_RX_PROTOCOL_CHECK_EN
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] pdata_q;
  logic [KB-1:0]         pkeep_q;
  logic                  plast_q;
  logic [7:0]            pdest_q;
  logic                  err_q;

  // Observes only: a stalled beat must stay asserted and unchanged until taken.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      stall_q <= 1'b0;
      pdata_q <= '0;
      pkeep_q <= '0;
      plast_q <= 1'b0;
      pdest_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= s.TVALID && !tready;
      pdata_q <= s.TDATA;
      pkeep_q <= s.TKEEP;
      plast_q <= s.TLAST;
      pdest_q <= s.TDEST;
      if (stall_q && (!s.TVALID || (s.TDATA != pdata_q) || (s.TKEEP != pkeep_q) ||
                      (s.TLAST != plast_q) || (s.TDEST != pdest_q)))
        err_q <= 1'b1;
      if (hs && !s.TLAST && (s.TKEEP == '0))
        err_q <= 1'b1;
      if (hs && ((s.TSTRB & ~s.TKEEP) != '0))
        err_q <= 1'b1;
    end
  end

  assign s.proto_err = err_q;
`else
  assign s.proto_err = 1'b0;
`endif
endmodule
